line_buf_scaler_ctrl: RTL and testbench
=======================================

// Module: line_buf_scaler_ctrl
// PURPOSE
//  Sequencer for a ring of NUM_LINES YCbCr422 line buffers feeding the vertical scaler.
//  Writes incoming lines into the ring in order: line L goes to buffer L mod NUM_LINES.
//  Grants scaler requests for source-line pairs (L, L+1) once both lines are resident.
//  Back-pressures the input when the next write would overwrite a line still needed.
// PARAMETERS
//  NUM_LINES  4   ring depth; power of two, >=2
//  SEL_W      2   log2(NUM_LINES)
//  ADDR_W     11  line-buffer address width (2048-pixel lines max)
//  LINE_W     12  line counter / v_active width
// PORTS
//  clk          in   1          single clock for write side, read side and all buffers
//  rst          in   1          asynchronous reset, active-high
//  h_active     in   ADDR_W     pixels per line; sampled at frame_start
//  v_active     in   LINE_W     lines per frame; sampled at frame_start
//  frame_start  in   1          pulse; starts a new frame and aborts any frame in progress
//  in_de        in   1          input pixel valid
//  in_ready     out  1          input may advance; a pixel transfers when in_de & in_ready
//  wr_addr      out  ADDR_W     pixel address to all buffers
//  wr_en        out  NUM_LINES  one-hot write enable, bit = current buffer
//  rd_req       in   1          scaler requests source line pair; held until rd_grant
//  rd_line      in   LINE_W     upper source line L of the pair; stable while rd_req is high
//  rd_grant     out  1          one-cycle pulse; pair is resident; L becomes the release mark
//  rd_sel0      out  SEL_W      buffer index holding line L; valid from rd_grant
//  rd_sel1      out  SEL_W      buffer index holding min(L+1, v_active-1); valid from rd_grant
//  frame_done   out  1          one-cycle pulse after the last pixel of line v_active-1 is written
// BEHAVIOUR
//  Reset: in_ready=0, wr_addr=0, wr_en=0, rd_grant=0, rd_sel0=rd_sel1=0, frame_done=0.
//   Internal: pix_cnt=0, wr_line=0, rel_line=0, state=IDLE.
//  Write FSM:
//   IDLE:    in_ready=0. On frame_start: latch h_active/v_active; pix_cnt=0; wr_line=0;
//            rel_line=0 -> CHECK.
//   CHECK:   if wr_line >= rel_line+NUM_LINES -> STALL; otherwise -> LINE.
//   STALL:   in_ready=0. Re-evaluate the CHECK condition every cycle; -> LINE when it clears.
//   LINE:    in_ready=1. Each transfer writes at wr_addr=pix_cnt with wr_en one-hot at
//            bit wr_line[SEL_W-1:0]; wr_addr/wr_en are combinational from state and in_de.
//            On transfer with pix_cnt==h_active-1: pix_cnt=0; wr_line+=1.
//             If wr_line+1==v_active -> DONE; otherwise -> CHECK.
//   DONE:    in_ready=0. Pulse frame_done one cycle -> IDLE.
//  frame_start in any state aborts: clear counters, re-latch h_active/v_active, -> CHECK.
//   No write occurs in that cycle.
//  h_active==0 or v_active==0 at frame_start: go straight to DONE; no writes.
//  Read side:
//   resident(L) = (L+1 <= wr_line) && (L + NUM_LINES > wr_line), evaluated on the
//    registered wr_line (lines fully written and not yet overwritten).
//   Grant condition: rd_req & resident(L) & resident(min(L+1, v_active-1)).
//   Grant timing: registered; rd_grant is high the cycle after the condition is met.
//    In the grant cycle: rd_sel0=L[SEL_W-1:0], rd_sel1=min(L+1, v_active-1)[SEL_W-1:0],
//    rel_line=L. rd_sel0/rd_sel1 hold until the next grant.
//   No second grant while rd_req stays high after a grant; the scaler drops rd_req for
//    at least one cycle between requests.
//   rel_line is monotonic within a frame. A request with L < rel_line is never granted;
//    the scaler must not issue one.
//  Simultaneous events:
//   Grant and write-line completion in the same cycle: both take effect.
//   STALL clears on the cycle after rel_line updates.
//   frame_start with rd_req: no grant that cycle; resident() is evaluated against the new frame.
//  Widths: all line comparisons done at LINE_W+1 bits, so rel_line+NUM_LINES does not wrap.
// TESTING
//  1. Throughput, no stall: h_active=8, v_active=3, in_de=1 continuously.
//     -> wr_en cycles 0001/0010/0100; wr_addr 0..7 per line;
//        frame_done 1 cycle after the 24th transfer.
//  2. Stall: h_active=4, v_active=8, no rd_req.
//     -> lines 0-3 written; in_ready=0 at line 4.
//     Then rd_req L=1 -> rd_grant, rd_sel0=1, rd_sel1=2; line 4 resumes into buffer 0.
//  3. Grant wait: rd_req L=2 while wr_line=2.
//     -> no grant until line 3 completes; then rd_grant next cycle, rd_sel0=2, rd_sel1=3.
//  4. Bottom edge: v_active=3, rd_req L=2 after frame end.
//     -> rd_grant, rd_sel0=rd_sel1=2.
//  5. Abort: frame_start mid-line (pix_cnt=5, wr_line=2).
//     -> no wr_en that cycle; next frame starts at buffer 0, wr_addr 0.
//  6. Reset mid-line with rd_req high: rst asserted async.
//     -> all outputs 0 immediately; after release, idle until frame_start.

Source files
------------

// File: rtl/line_buf_scaler_ctrl_if.sv
// Handshake and buffer-control bundle between the video source / scaler side
// and the line-buffer ring sequencer.
interface line_buf_scaler_ctrl_if #(
   parameter int NUM_LINES = 4,
   parameter int SEL_W     = 2,
   parameter int ADDR_W    = 11,
   parameter int LINE_W    = 12
);
   logic [ADDR_W-1:0]    h_active;
   logic [LINE_W-1:0]    v_active;
   logic                 frame_start;
   logic                 in_de;
   logic                 in_ready;
   logic [ADDR_W-1:0]    wr_addr;
   logic [NUM_LINES-1:0] wr_en;
   logic                 rd_req;
   logic [LINE_W-1:0]    rd_line;
   logic                 rd_grant;
   logic [SEL_W-1:0]     rd_sel0;
   logic [SEL_W-1:0]     rd_sel1;
   logic                 frame_done;

   // Source/scaler side: drives frame setup, pixels and line-pair requests.
   modport master (
      output h_active, v_active, frame_start, in_de, rd_req, rd_line,
      input  in_ready, wr_addr, wr_en, rd_grant, rd_sel0, rd_sel1, frame_done
   );

   // Sequencer side.
   modport slave (
      input  h_active, v_active, frame_start, in_de, rd_req, rd_line,
      output in_ready, wr_addr, wr_en, rd_grant, rd_sel0, rd_sel1, frame_done
   );
endinterface

// File: rtl/line_buf_scaler_ctrl.sv
// Sequencer for a ring of NUM_LINES line buffers feeding a vertical scaler.
// Line L is written into buffer L mod NUM_LINES; the scaler is granted a
// source-line pair once both lines are resident, and the granted upper line
// becomes the release mark that bounds how far the writer may run ahead.
module line_buf_scaler_ctrl #(
   parameter int NUM_LINES = 4,
   parameter int SEL_W     = 2,
   parameter int ADDR_W    = 11,
   parameter int LINE_W    = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   line_buf_scaler_ctrl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, CHECK, STALL, LINE, DONE} state_t;

   localparam logic [LINE_W:0]   ONE_L = (LINE_W+1)'(1);
   localparam logic [LINE_W:0]   RING  = (LINE_W+1)'(NUM_LINES);
   localparam logic [LINE_W-1:0] ONE_W = LINE_W'(1);
   localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

   state_t               state;
   state_t               state_d;
   logic [ADDR_W-1:0]    pix_cnt;
   logic [LINE_W-1:0]    wr_line;
   logic [LINE_W-1:0]    rel_line;
   logic [ADDR_W-1:0]    h_lat;
   logic [LINE_W-1:0]    v_lat;
   logic                 served;
   logic                 grant_p1;
   logic [SEL_W-1:0]     sel0_p1;
   logic [SEL_W-1:0]     sel1_p1;

   logic [LINE_W:0]      wr_ext;
   logic [LINE_W:0]      rel_ext;
   logic [LINE_W:0]      line_ext;
   logic [LINE_W:0]      last_ext;
   logic [LINE_W:0]      pair_ext;
   logic                 stall_cond;
   logic                 line_last;
   logic                 frame_last;
   logic                 size_zero;
   logic                 grant_cond;
   logic                 ready;
   logic                 done_pulse;
   logic                 xfer;
   logic [NUM_LINES-1:0] sel_hot;

   // A line is resident once fully written and not yet overwritten by the ring.
   function automatic logic resident(input logic [LINE_W:0] l, input logic [LINE_W:0] w);
      return ((l + ONE_L) <= w) && ((l + RING) > w);
   endfunction

   // Line arithmetic, widened by one bit so rel_line + NUM_LINES cannot wrap.
   always_comb begin
      wr_ext     = {1'b0, wr_line};
      rel_ext    = {1'b0, rel_line};
      line_ext   = {1'b0, bus.rd_line};
      last_ext   = {1'b0, v_lat} - ONE_L;
      pair_ext   = ((line_ext + ONE_L) < last_ext) ? (line_ext + ONE_L) : last_ext;
      stall_cond = wr_ext >= (rel_ext + RING);
      line_last  = pix_cnt == (h_lat - ONE_A);
      frame_last = (wr_ext + ONE_L) == {1'b0, v_lat};
      size_zero  = (bus.h_active == '0) || (bus.v_active == '0);
      grant_cond = bus.rd_req && !served && !bus.frame_start
                   && resident(line_ext, wr_ext) && resident(pair_ext, wr_ext);
   end

   // One-hot buffer select for the line currently being written.
   always_comb begin
      sel_hot = '0;
      sel_hot[wr_line[SEL_W-1:0]] = 1'b1;
   end

   // Write FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // Write FSM next state and handshake; frame_start overrides every state.
   always_comb begin
      state_d    = state;
      ready      = 1'b0;
      done_pulse = 1'b0;
      case (state)
         IDLE:  ;
         CHECK: state_d = stall_cond ? STALL : LINE;
         STALL: if (!stall_cond) state_d = LINE;
         LINE: begin
            ready = !bus.frame_start;
            if (ready && bus.in_de && line_last) state_d = frame_last ? DONE : CHECK;
         end
         DONE: begin
            done_pulse = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (bus.frame_start) state_d = size_zero ? DONE : CHECK;
   end

   assign xfer           = ready && bus.in_de;
   assign bus.in_ready   = ready;
   assign bus.wr_addr    = xfer ? pix_cnt : '0;
   assign bus.wr_en      = xfer ? sel_hot : '0;
   assign bus.frame_done = done_pulse;

   // Frame geometry latch plus pixel and line counters of the write side.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_cnt <= '0;
         wr_line <= '0;
         h_lat   <= '0;
         v_lat   <= '0;
      end else if (bus.frame_start) begin
         pix_cnt <= '0;
         wr_line <= '0;
         h_lat   <= bus.h_active;
         v_lat   <= bus.v_active;
      end else if (xfer) begin
         if (line_last) begin
            pix_cnt <= '0;
            wr_line <= wr_line + ONE_W;
         end else begin
            pix_cnt <= pix_cnt + ONE_A;
         end
      end
   end

   // Registered grant; one grant per request, and the granted line becomes the release mark.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_p1 <= 1'b0;
         sel0_p1  <= '0;
         sel1_p1  <= '0;
         rel_line <= '0;
         served   <= 1'b0;
      end else begin
         grant_p1 <= grant_cond;
         if (grant_cond) begin
            sel0_p1 <= bus.rd_line[SEL_W-1:0];
            sel1_p1 <= pair_ext[SEL_W-1:0];
         end
         if (bus.frame_start)  rel_line <= '0;
         else if (grant_cond)  rel_line <= bus.rd_line;
         if (!bus.rd_req)      served <= 1'b0;
         else if (grant_cond)  served <= 1'b1;
      end
   end

   assign bus.rd_grant = grant_p1;
   assign bus.rd_sel0  = sel0_p1;
   assign bus.rd_sel1  = sel1_p1;

endmodule

// File: tb/tb_line_buf_scaler_ctrl.sv
// Testbench for line_buf_scaler_ctrl: scoreboarded writes and grants.
module tb_line_buf_scaler_ctrl;

   typedef struct packed {
      logic [3:0]  en;
      logic [10:0] addr;
   } wr_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   xfer_total;
   wr_t  wr_q[$];
   logic [3:0] gnt_q[$];
   wr_t  mon_e;
   logic [3:0] mon_g;

   line_buf_scaler_ctrl_if bus ();

   line_buf_scaler_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: every transfer pops an expected write, every grant an expected pair.
   always @(negedge clk) begin
      if (bus.in_de === 1'b1 && bus.in_ready === 1'b1) begin
         xfer_total++;
         checks++;
         if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected en=%b addr=%0d required no write", bus.wr_en, bus.wr_addr);
         end else begin
            mon_e = wr_q.pop_front();
            if (bus.wr_en !== mon_e.en || bus.wr_addr !== mon_e.addr) begin
               errors++;
               $display("FAIL wr_data en=%b addr=%0d required en=%b addr=%0d",
                        bus.wr_en, bus.wr_addr, mon_e.en, mon_e.addr);
            end
         end
      end else if (bus.wr_en !== 4'b0000) begin
         checks++;
         errors++;
         $display("FAIL wr_en_idle en=%b required 0000", bus.wr_en);
      end
      if (bus.rd_grant === 1'b1) begin
         checks++;
         if (gnt_q.size() == 0) begin
            errors++;
            $display("FAIL grant_unexpected sel0=%0d sel1=%0d required no grant", bus.rd_sel0, bus.rd_sel1);
         end else begin
            mon_g = gnt_q.pop_front();
            if ({bus.rd_sel0, bus.rd_sel1} !== mon_g) begin
               errors++;
               $display("FAIL grant_sel sel0=%0d sel1=%0d required sel0=%0d sel1=%0d",
                        bus.rd_sel0, bus.rd_sel1, mon_g[3:2], mon_g[1:0]);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog run exceeded time limit, required completion");
      $fatal(1, "bench timeout");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive_frame_start(input int h, input int v);
      wr_t e;
      @(posedge clk);
      #1;
      bus.h_active    = h[10:0];
      bus.v_active    = v[11:0];
      bus.frame_start = 1'b1;
      wr_q.delete();
      for (int l = 0; l < v; l++) begin
         for (int p = 0; p < h; p++) begin
            e.en   = 4'b0001 << (l % 4);
            e.addr = p[10:0];
            wr_q.push_back(e);
         end
      end
   endtask

   task automatic release_frame_start();
      @(posedge clk);
      #1;
      bus.frame_start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max_cyc);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < max_cyc && !seen; n++) begin
         tick();
         if (bus.frame_done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s frame_done not seen in %0d cycles, required pulse", name, max_cyc);
      end
      checks++;
      if (wr_q.size() != 0) begin
         errors++;
         $display("FAIL %s writes_left=%0d required 0", name, wr_q.size());
         wr_q.delete();
      end
   endtask

   task automatic do_grant(input int l, input int e0, input int e1);
      bit got;
      got = 1'b0;
      @(posedge clk);
      #1;
      bus.rd_line = l[11:0];
      bus.rd_req  = 1'b1;
      gnt_q.push_back({e0[1:0], e1[1:0]});
      for (int n = 0; n < 80 && !got; n++) begin
         tick();
         if (bus.rd_grant === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL grant_timeout line=%0d rd_grant=0 required 1", l);
         gnt_q.delete();
      end
      @(posedge clk);
      #1;
      bus.rd_req = 1'b0;
      tick();
      checks++;
      if (bus.rd_grant !== 1'b0) begin
         errors++;
         $display("FAIL grant_pulse line=%0d rd_grant=%b required 0", l, bus.rd_grant);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.in_ready, bus.wr_addr, bus.wr_en, bus.rd_grant, bus.rd_sel0, bus.rd_sel1, bus.frame_done} !== '0) begin
         errors++;
         $display("FAIL reset_outputs rdy=%b addr=%0d en=%b gnt=%b s0=%0d s1=%0d done=%b required all 0",
                  bus.in_ready, bus.wr_addr, bus.wr_en, bus.rd_grant, bus.rd_sel0, bus.rd_sel1, bus.frame_done);
      end
      rst = 1'b0;
      bus.in_de = 1'b1;
      repeat (5) begin
         tick();
         checks++;
         if (bus.in_ready !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle in_ready=%b frame_done=%b required 0 0", bus.in_ready, bus.frame_done);
         end
      end
   endtask

   task automatic test_throughput();
      int cnt, cyc, last, done_cyc;
      cnt = 0; cyc = 0; last = -10; done_cyc = -1;
      drive_frame_start(8, 3);
      release_frame_start();
      for (int n = 0; n < 120 && done_cyc < 0; n++) begin
         tick();
         cyc++;
         if (bus.in_de === 1'b1 && bus.in_ready === 1'b1) begin
            cnt++;
            last = cyc;
         end
         if (bus.frame_done === 1'b1) done_cyc = cyc;
      end
      checks++;
      if (cnt != 24) begin
         errors++;
         $display("FAIL thru_count transfers=%0d required 24", cnt);
      end
      checks++;
      if (done_cyc != last + 1) begin
         errors++;
         $display("FAIL thru_done_timing done_cycle=%0d required %0d", done_cyc, last + 1);
      end
      checks++;
      if (wr_q.size() != 0) begin
         errors++;
         $display("FAIL thru_writes_left=%0d required 0", wr_q.size());
         wr_q.delete();
      end
   endtask

   task automatic test_bottom_edge();
      do_grant(1, 1, 2);
      do_grant(2, 2, 2);
   endtask

   task automatic test_stall();
      int base;
      drive_frame_start(4, 8);
      base = xfer_total;
      release_frame_start();
      repeat (60) tick();
      checks++;
      if (xfer_total - base != 16 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL stall_first transfers=%0d in_ready=%b required 16 0", xfer_total - base, bus.in_ready);
      end
      do_grant(1, 1, 2);
      repeat (30) tick();
      checks++;
      if (xfer_total - base != 20 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL stall_second transfers=%0d in_ready=%b required 20 0", xfer_total - base, bus.in_ready);
      end
      do_grant(2, 2, 3);
      do_grant(3, 3, 0);
      do_grant(4, 0, 1);
      do_grant(5, 1, 2);
      wait_done("stall_done", 100);
   endtask

   task automatic test_grant_wait();
      int base, cyc, t_last, t_done, t_gnt;
      cyc = 0; t_last = -1; t_done = -1; t_gnt = -1;
      drive_frame_start(16, 4);
      base = xfer_total;
      release_frame_start();
      for (int n = 0; n < 200 && (xfer_total - base) < 32; n++) tick();
      @(posedge clk);
      #1;
      bus.rd_line = 12'd2;
      bus.rd_req  = 1'b1;
      gnt_q.push_back({2'd2, 2'd3});
      for (int n = 0; n < 200 && t_gnt < 0; n++) begin
         tick();
         cyc++;
         if (bus.in_de === 1'b1 && bus.in_ready === 1'b1 && (xfer_total - base) == 64) t_last = cyc;
         if (bus.frame_done === 1'b1) t_done = cyc;
         if (bus.rd_grant === 1'b1) t_gnt = cyc;
      end
      checks++;
      if (t_last < 0 || t_done != t_last + 1) begin
         errors++;
         $display("FAIL gw_done_timing done_cycle=%0d required %0d", t_done, t_last + 1);
      end
      checks++;
      if (t_last < 0 || t_gnt != t_last + 2) begin
         errors++;
         $display("FAIL gw_grant_timing grant_cycle=%0d required %0d", t_gnt, t_last + 2);
         gnt_q.delete();
      end
      @(posedge clk);
      #1;
      bus.rd_req = 1'b0;
      tick();
      checks++;
      if (bus.rd_grant !== 1'b0) begin
         errors++;
         $display("FAIL gw_grant_pulse rd_grant=%b required 0", bus.rd_grant);
      end
   endtask

   task automatic test_abort();
      int base;
      bit seen;
      seen = 1'b0;
      drive_frame_start(8, 4);
      base = xfer_total;
      release_frame_start();
      for (int n = 0; n < 200 && (xfer_total - base) < 21; n++) tick();
      drive_frame_start(8, 2);
      tick();
      checks++;
      if (bus.wr_en !== 4'b0000 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_cycle wr_en=%b in_ready=%b required 0000 0", bus.wr_en, bus.in_ready);
      end
      release_frame_start();
      for (int n = 0; n < 20 && !seen; n++) begin
         tick();
         if (bus.in_de === 1'b1 && bus.in_ready === 1'b1) begin
            seen = 1'b1;
            checks++;
            if (bus.wr_en !== 4'b0001 || bus.wr_addr !== 11'd0) begin
               errors++;
               $display("FAIL abort_first wr_en=%b addr=%0d required 0001 0", bus.wr_en, bus.wr_addr);
            end
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL abort_restart no transfer, required one");
      end
      wait_done("abort_done", 100);
   endtask

   task automatic test_zero_size();
      int base;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) drive_frame_start(0, 3);
         else        drive_frame_start(5, 0);
         base = xfer_total;
         release_frame_start();
         tick();
         checks++;
         if (bus.frame_done !== 1'b1) begin
            errors++;
            $display("FAIL zero_done case=%0d frame_done=%b required 1", k, bus.frame_done);
         end
         tick();
         checks++;
         if (bus.frame_done !== 1'b0 || bus.in_ready !== 1'b0 || xfer_total != base) begin
            errors++;
            $display("FAIL zero_after case=%0d done=%b rdy=%b transfers=%0d required 0 0 0",
                     k, bus.frame_done, bus.in_ready, xfer_total - base);
         end
      end
   endtask

   task automatic test_reset_mid();
      int base;
      drive_frame_start(8, 4);
      base = xfer_total;
      release_frame_start();
      for (int n = 0; n < 100 && (xfer_total - base) < 10; n++) tick();
      @(posedge clk);
      #1;
      bus.rd_line = 12'd0;
      bus.rd_req  = 1'b1;
      tick();
      #2;
      rst = 1'b1;
      wr_q.delete();
      #1;
      checks++;
      if ({bus.in_ready, bus.wr_addr, bus.wr_en, bus.rd_grant, bus.rd_sel0, bus.rd_sel1, bus.frame_done} !== '0) begin
         errors++;
         $display("FAIL rst_async rdy=%b addr=%0d en=%b gnt=%b s0=%0d s1=%0d done=%b required all 0",
                  bus.in_ready, bus.wr_addr, bus.wr_en, bus.rd_grant, bus.rd_sel0, bus.rd_sel1, bus.frame_done);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (8) begin
         tick();
         checks++;
         if (bus.in_ready !== 1'b0 || bus.rd_grant !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle in_ready=%b rd_grant=%b required 0 0", bus.in_ready, bus.rd_grant);
         end
      end
      bus.rd_req = 1'b0;
      drive_frame_start(2, 1);
      release_frame_start();
      wait_done("rst_restart", 40);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      xfer_total = 0;
      rst = 1'b0;
      bus.h_active    = '0;
      bus.v_active    = '0;
      bus.frame_start = 1'b0;
      bus.in_de       = 1'b0;
      bus.rd_req      = 1'b0;
      bus.rd_line     = '0;
      #1;
      rst = 1'b1;
      test_reset();
      test_throughput();
      test_bottom_edge();
      test_stall();
      test_grant_wait();
      test_abort();
      test_zero_size();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
